alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer that shares one 16-bit
// combinational arithmetic unit among NREQ requesters.
//
// A request (operands, 4-bit select, carry-in) is accepted over a
// valid/ready handshake. The winner's payload is registered and driven onto
// the unit for one full cycle. The unit's result, carry and compare flag are
// captured and returned with the requester id over a second valid/ready
// handshake.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready[NREQ]  request handshake, ready is one-hot or zero
//   req_a/req_b[NREQ*16]       operands, requester i at [16i+15:16i]
//   req_sel[NREQ*4]            select, requester i at [4i+3:4i]
//   req_cin[NREQ]              carry-in
//   alu_a/alu_b/alu_sel/alu_cin  registered operands to the unit
//   alu_res/alu_cout/alu_cmp   unit outputs
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/rsp_data/rsp_cout/rsp_cmp  captured response
//   op_count, stall_count      only with ALU_ARB_PERF_EN defined: count of
//                              response handshakes and of stalled RESP cycles
//
// Optional macro: ALU_ARB_PERF_EN (adds the two performance counters).
//
// Timing: accept in cycle 0, EXEC in cycle 1, rsp_valid in cycle 2; one
// operation per 3 cycles at best.

module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  input  logic [NREQ*4-1:0] req_sel,
  input  logic [NREQ-1:0]   req_cin,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [3:0]        alu_sel,
  output logic              alu_cin,
  input  logic [15:0]       alu_res,
  input  logic              alu_cout,
  input  logic              alu_cmp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_data,
  output logic              rsp_cout,
`ifdef ALU_ARB_PERF_EN
  output logic [15:0]       op_count,
  output logic [15:0]       stall_count,
`endif
  output logic              rsp_cmp
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;

  // Packed views: element i lines up with bits [W*i+W-1:W*i] of the flat bus.
  logic [NREQ-1:0][15:0] a_arr, b_arr;
  logic [NREQ-1:0][3:0]  sel_arr;

  assign a_arr   = req_a;
  assign b_arr   = req_b;
  assign sel_arr = req_sel;

  logic [IDW-1:0] last, winner, cand;
  logic           any_vld;

  // Round-robin pick: scan last+1, last+2, ... (mod NREQ); first valid wins.
  always_comb begin
    winner  = '0;
    cand    = '0;
    any_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last) + k) % NREQ);
      if (!any_vld && req_valid[cand]) begin
        any_vld = 1'b1;
        winner  = cand;
      end
    end
  end

  wire grant = (state == IDLE) && any_vld;

  // Gated by rst_n so ready reads zero for as long as reset is held, even
  // with requests pending.
  always_comb begin
    req_ready = '0;
    if (grant && rst_n) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDW'(NREQ - 1);
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      alu_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
      rsp_cmp   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        alu_a   <= a_arr[winner];
        alu_b   <= b_arr[winner];
        alu_sel <= sel_arr[winner];
        alu_cin <= req_cin[winner];
        last    <= winner;
        rsp_id  <= winner;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_res;
        rsp_cout  <= alu_cout;
        rsp_cmp   <= alu_cmp;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  // Free-running, wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (rsp_valid && rsp_ready)        op_count    <= op_count + 16'd1;
      if (state == RESP && !rsp_ready)   stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter (NREQ=4) with a small behavioural
// arithmetic unit: sel 4'b1001 = a+b+cin, anything else passes a through;
// cmp = (a == b).
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0, req_ready, req_cin = '0;
  logic [NREQ*16-1:0] req_a = '0, req_b = '0;
  logic [NREQ*4-1:0]  req_sel = '0;
  logic [15:0] alu_a, alu_b, alu_res, rsp_data;
  logic [3:0]  alu_sel;
  logic alu_cin, alu_cout, alu_cmp, rsp_valid, rsp_ready = 1'b1, rsp_cout, rsp_cmp;
  logic [IDW-1:0] rsp_id;
`ifdef ALU_ARB_PERF_EN
  logic [15:0] op_count, stall_count;
`endif

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_cmp(alu_cmp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout),
`ifdef ALU_ARB_PERF_EN
    .op_count(op_count), .stall_count(stall_count),
`endif
    .rsp_cmp(rsp_cmp)
  );

  always_comb begin
    {alu_cout, alu_res} = {1'b0, alu_a};
    if (alu_sel == 4'b1001)
      {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_cin);
    alu_cmp = (alu_a == alu_b);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sel, input logic cin);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_sel[4*i +: 4] = sel;
    req_cin[i]        = cin;
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] m;
    m = '0; m[i] = 1'b1;
    return m;
  endfunction

  // Single op from IDLE with only requester idx valid and rsp_ready high.
  task automatic do_op(input string tag, input int idx, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] sel, input logic cin,
                       input logic [15:0] ed, input logic ec, input logic ecmp);
    set_req(idx, a, b, sel, cin);
    req_valid[idx] = 1'b1;
    #1 chk({tag, "_ready"}, 32'(req_ready), 32'(oh(idx)));
    tick();
    req_valid[idx] = 1'b0;
    chk({tag, "_exec_vld"}, 32'(rsp_valid), 0);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'(a));
    tick();
    chk({tag, "_vld"},  32'(rsp_valid), 1);
    chk({tag, "_data"}, 32'(rsp_data), 32'(ed));
    chk({tag, "_cout"}, 32'(rsp_cout), 32'(ec));
    chk({tag, "_cmp"},  32'(rsp_cmp), 32'(ecmp));
    chk({tag, "_id"},   32'(rsp_id), 32'(idx));
    tick();
    chk({tag, "_done"}, 32'(rsp_valid), 0);
  endtask

  logic [15:0] exp_d [4] = '{16'h0010, 16'h0021, 16'h0032, 16'h0043};

  initial begin
    // Reset state, with a request already pending.
    req_valid = 4'b0001;
    #2;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_vld",   32'(rsp_valid), 0);
    chk("rst_data",  32'(rsp_data), 0);
    chk("rst_id",    32'(rsp_id), 0);
    chk("rst_alu",   32'({alu_a, alu_b}), 0);
    chk("rst_sel",   32'({alu_sel, alu_cin, rsp_cout, rsp_cmp}), 0);
    req_valid = '0;
    do_reset();

    // Single op, carry, compare.
    do_op("add",   0, 16'h0003, 16'h0004, 4'b1001, 1'b0, 16'h0007, 1'b0, 1'b0);
    do_op("carry", 0, 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("cmp",   1, 16'h1234, 16'h1234, 4'b1001, 1'b0, 16'h2468, 1'b0, 1'b1);
    do_op("cin",   3, 16'h00FF, 16'h0000, 4'b1001, 1'b1, 16'h0100, 1'b0, 1'b0);

    // All four valid from reset: grants 0,1,2,3 on a 3-cycle beat.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(16'h0010 * (i + 1)), 16'(i), 4'b1001, 1'b0);
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < NREQ; g++) begin
      chk($sformatf("rr_grant%0d", g), 32'(req_ready), 32'(oh(g)));
      tick();
      req_valid[g] = 1'b0;
      chk($sformatf("rr_exec_rdy%0d", g), 32'(req_ready), 0);
      tick();
      chk($sformatf("rr_resp_rdy%0d", g), 32'(req_ready), 0);
      chk($sformatf("rr_id%0d", g),   32'(rsp_id), 32'(g));
      chk($sformatf("rr_data%0d", g), 32'(rsp_data), 32'(exp_d[g]));
      tick();
    end

    // Fairness: after serving 2, with 0 and 3 valid, 3 goes first.
    do_reset();
    do_op("fair2", 2, 16'h0001, 16'h0001, 4'b1001, 1'b0, 16'h0002, 1'b0, 1'b1);
    set_req(0, 16'hAAAA, 16'h0000, 4'b0000, 1'b0);
    set_req(3, 16'h5555, 16'h0000, 4'b0000, 1'b0);
    req_valid = 4'b1001;
    #1 chk("fair_first", 32'(req_ready), 32'b1000);
    tick(); req_valid[3] = 1'b0; tick();
    chk("fair_id3",   32'(rsp_id), 3);
    chk("fair_data3", 32'(rsp_data), 32'h5555);
    tick();
    chk("fair_second", 32'(req_ready), 32'b0001);
    tick(); req_valid[0] = 1'b0; tick();
    chk("fair_id0",   32'(rsp_id), 0);
    chk("fair_data0", 32'(rsp_data), 32'hAAAA);
    tick();

    // Backpressure: 5 stalled RESP cycles, rsp held, no grants.
    do_reset();
    set_req(0, 16'h1234, 16'h1234, 4'b1001, 1'b0);
    set_req(1, 16'h0001, 16'h0002, 4'b1001, 1'b0);
    req_valid = 4'b0001;
    tick(); req_valid = 4'b0010; tick();
    rsp_ready = 1'b0;
    chk("bp_vld", 32'(rsp_valid), 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_hold_vld%0d", c),  32'(rsp_valid), 1);
      chk($sformatf("bp_hold_data%0d", c), 32'(rsp_data), 32'h2468);
      chk($sformatf("bp_hold_rdy%0d", c),  32'(req_ready), 0);
    end
    chk("bp_alu_a", 32'(alu_a), 32'h1234);
    rsp_ready = 1'b1;
    tick();
    chk("bp_released", 32'(rsp_valid), 0);
    chk("bp_next_grant", 32'(req_ready), 32'b0010);
`ifdef ALU_ARB_PERF_EN
    chk("perf_stall", 32'(stall_count), 5);
    chk("perf_ops",   32'(op_count), 1);
`endif
    tick(); req_valid = '0; tick();
    chk("bp_next_id", 32'(rsp_id), 1);
    chk("bp_next_data", 32'(rsp_data), 32'h0003);
    tick();

    // Reset during EXEC: outputs clear at once, no response, pointer reset.
    do_reset();
    do_op("pre", 0, 16'h0002, 16'h0002, 4'b1001, 1'b0, 16'h0004, 1'b0, 1'b1);
    set_req(1, 16'h0F0F, 16'h0001, 4'b1001, 1'b0);
    req_valid = 4'b0010;
    tick();
    chk("mid_exec_alu", 32'(alu_a), 32'h0F0F);
    req_valid = 4'b0110;
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 32'(req_ready), 0);
    chk("mid_vld",   32'(rsp_valid), 0);
    chk("mid_alu",   32'({alu_a, alu_b}), 0);
    chk("mid_sel",   32'({alu_sel, alu_cin}), 0);
    chk("mid_rsp",   32'({rsp_data, 14'(rsp_id), rsp_cout, rsp_cmp}), 0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mid_no_rsp%0d", c), 32'(rsp_valid), 0);
    end
    req_valid = 4'b0111;
    #1 chk("mid_prio0", 32'(req_ready), 32'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
